// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the instruction-fetch
// requester (IF, owner 0) and the load/store requester (D, owner 1) using the
// MFA/MFC handshake on both sides. One RAM transaction at a time, round-robin
// on simultaneous requests, all outputs registered.
// Optional feature: define ARB_TIMEOUT_EN to bound the wait for RAM_MFC to
// TIMEOUT cycles and report MEM_ERR; otherwise BUSY waits indefinitely.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  // Instruction-fetch requester
  input  logic          IF_MFA,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_MFC,
  output logic [DW-1:0] IF_RDATA,
  // Load/store requester
  input  logic          D_MFA,
  input  logic          D_RW,
  input  logic [1:0]    D_SIZE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_MFC,
  output logic [DW-1:0] D_RDATA,
  // RAM side
  output logic          RAM_MFA,
  output logic          RAM_RW,
  output logic [1:0]    RAM_SIZE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA,
  input  logic          RAM_MFC,
  // Status
  output logic [1:0]    GNT,
  output logic          MEM_ERR
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Owner / last-served encoding: 0 = IF, 1 = D.
  localparam logic OwnIf = 1'b0;
  localparam logic OwnD  = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          abort_q, abort_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          ram_mfa_q, ram_mfa_d;
  logic          ram_rw_q, ram_rw_d;
  logic [1:0]    ram_size_q, ram_size_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          if_mfc_q, if_mfc_d;
  logic          d_mfc_q, d_mfc_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
`endif

  logic pick_d;     // winner of an IDLE-state arbitration is D
  logic owner_mfa;  // current owner's request line
  logic abort_now;  // owner has withdrawn its request at some point in BUSY

  // Next-state logic: arbitration, transaction tracking and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    abort_d     = abort_q;
    gnt_d       = gnt_q;
    ram_mfa_d   = ram_mfa_q;
    ram_rw_d    = ram_rw_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_mfc_d    = if_mfc_q;
    d_mfc_d     = d_mfc_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
`endif
    // D wins when alone, or on a tie when IF was served last.
    pick_d    = D_MFA && (!IF_MFA || (last_q == OwnIf));
    owner_mfa = (owner_q == OwnD) ? D_MFA : IF_MFA;
    abort_now = abort_q || !owner_mfa;

    case (state_q)
      StIdle: begin
        if (D_MFA || IF_MFA) begin
          owner_d     = pick_d;
          last_d      = pick_d;
          gnt_d       = pick_d ? 2'b10 : 2'b01;
          ram_addr_d  = pick_d ? D_ADDR : IF_ADDR;
          ram_rw_d    = pick_d ? D_RW : 1'b1;
          ram_size_d  = pick_d ? D_SIZE : 2'b10;
          ram_wdata_d = pick_d ? D_WDATA : '0;
          ram_mfa_d   = 1'b1;
          abort_d     = 1'b0;
          state_d     = StBusy;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      StBusy: begin
        // A withdrawn request is remembered so a later re-raise cannot revive it.
        abort_d = abort_now;
        if (RAM_MFC) begin
          ram_mfa_d = 1'b0;
          state_d   = StDone;
          if (!abort_now) begin
            if (owner_q == OwnD) begin
              d_mfc_d = 1'b1;
              if (ram_rw_q) begin
                d_rdata_d = RAM_RDATA;
              end
            end else begin
              if_mfc_d   = 1'b1;
              if_rdata_d = RAM_RDATA;
            end
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          ram_mfa_d = 1'b0;
          state_d   = StDone;
          if (!abort_now) begin
            mem_err_d = 1'b1;
            if (owner_q == OwnD) begin
              d_mfc_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_mfc_d   = 1'b1;
              if_rdata_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      StDone: begin
        // Aborted transactions only wait for the RAM to release its MFC.
        if ((abort_q || !owner_mfa) && !RAM_MFC) begin
          if_mfc_d = 1'b0;
          d_mfc_d  = 1'b0;
          gnt_d    = 2'b00;
          state_d  = StIdle;
`ifdef ARB_TIMEOUT_EN
          mem_err_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      last_q      <= OwnIf;
      abort_q     <= 1'b0;
      gnt_q       <= 2'b00;
      ram_mfa_q   <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_size_q  <= 2'b00;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_mfc_q    <= 1'b0;
      d_mfc_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      gnt_q       <= gnt_d;
      ram_mfa_q   <= ram_mfa_d;
      ram_rw_q    <= ram_rw_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_mfc_q    <= if_mfc_d;
      d_mfc_q     <= d_mfc_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign IF_MFC    = if_mfc_q;
  assign IF_RDATA  = if_rdata_q;
  assign D_MFC     = d_mfc_q;
  assign D_RDATA   = d_rdata_q;
  assign RAM_MFA   = ram_mfa_q;
  assign RAM_RW    = ram_rw_q;
  assign RAM_SIZE  = ram_size_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;
  assign GNT       = gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign MEM_ERR   = mem_err_q;
`else
  assign MEM_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple RAM model
// whose completion delay is set per test (ram_wait cycles after RAM_MFA).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_mfa;
  logic [AW-1:0] if_addr;
  logic          if_mfc;
  logic [DW-1:0] if_rdata;
  logic          d_mfa;
  logic          d_rw;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_mfc;
  logic [DW-1:0] d_rdata;
  logic          ram_mfa;
  logic          ram_rw;
  logic [1:0]    ram_size;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_mfc;
  logic [1:0]    gnt;
  logic          mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ram_wait = 0;
  int ram_cnt  = 0;

  mem_port_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .TIMEOUT(16)
  ) u_dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .IF_MFA   (if_mfa),
    .IF_ADDR  (if_addr),
    .IF_MFC   (if_mfc),
    .IF_RDATA (if_rdata),
    .D_MFA    (d_mfa),
    .D_RW     (d_rw),
    .D_SIZE   (d_size),
    .D_ADDR   (d_addr),
    .D_WDATA  (d_wdata),
    .D_MFC    (d_mfc),
    .D_RDATA  (d_rdata),
    .RAM_MFA  (ram_mfa),
    .RAM_RW   (ram_rw),
    .RAM_SIZE (ram_size),
    .RAM_ADDR (ram_addr),
    .RAM_WDATA(ram_wdata),
    .RAM_RDATA(ram_rdata),
    .RAM_MFC  (ram_mfc),
    .GNT      (gnt),
    .MEM_ERR  (mem_err)
  );

  always #5 clk = ~clk;

  // RAM model: asserts MFC once RAM_MFA has been seen for ram_wait+1 negedges
  always @(negedge clk) begin
    if (ram_mfa) begin
      ram_mfc <= (ram_cnt >= ram_wait);
      ram_cnt <= ram_cnt + 1;
    end else begin
      ram_mfc <= 1'b0;
      ram_cnt <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] ram_snap;
  int           cyc;

  initial begin
    ram_mfc   = 1'b0;
    rst_n     = 1'b0;
    if_mfa    = 1'b0;
    if_addr   = '0;
    d_mfa     = 1'b0;
    d_rw      = 1'b1;
    d_size    = 2'b10;
    d_addr    = '0;
    d_wdata   = '0;
    ram_rdata = '0;

    // Reset state
    tick();
    tick();
    check_eq("reset_ctrl", {ram_mfa, gnt, if_mfc, d_mfc, mem_err}, '0);
    check_eq("reset_data", {ram_addr, ram_wdata, if_rdata, d_rdata}, '0);
    rst_n = 1'b1;
    tick();

    // IF fetch with zero-wait RAM
    ram_wait  = 0;
    ram_rdata = 32'hA2044012;
    if_mfa    = 1'b1;
    if_addr   = 32'h04;
    tick();
    check_eq("if_req", {ram_mfa, gnt, ram_rw, ram_size, if_mfc}, {1'b1, 2'b01, 1'b1, 2'b10, 1'b0});
    check_eq("if_addr", ram_addr, 32'h04);
    tick();
    check_eq("if_done", {if_mfc, d_mfc, ram_mfa}, 3'b100);
    check_eq("if_rdata", if_rdata, 32'hA2044012);
    if_mfa = 1'b0;
    tick();
    check_eq("if_idle", {if_mfc, gnt}, 3'b000);

    // Simultaneous pair straight after reset: D first, then IF
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    ram_rdata = 32'h11112222;
    d_rw      = 1'b1;
    d_size    = 2'b10;
    d_addr    = 32'h30;
    if_addr   = 32'h08;
    if_mfa    = 1'b1;
    d_mfa     = 1'b1;
    tick();
    check_eq("tie1_gnt_d", {gnt, ram_addr}, {2'b10, 32'h30});
    tick();
    check_eq("tie1_d_done", {d_mfc, if_mfc, d_rdata}, {1'b1, 1'b0, 32'h11112222});
    d_mfa     = 1'b0;
    ram_rdata = 32'h33334444;
    tick();
    check_eq("tie1_idle", {gnt, d_mfc}, 3'b000);
    tick();
    check_eq("tie1_gnt_if", {gnt, ram_addr}, {2'b01, 32'h08});
    tick();
    check_eq("tie1_if_done", {if_mfc, d_mfc, if_rdata}, {1'b1, 1'b0, 32'h33334444});
    if_mfa = 1'b0;
    tick();

    // D half-word write with a 5-cycle RAM; later input changes must be ignored
    ram_wait = 5;
    d_rw     = 1'b0;
    d_size   = 2'b01;
    d_addr   = 32'h20;
    d_wdata  = 32'hDEADBEEF;
    d_mfa    = 1'b1;
    tick();
    ram_snap = {59'd0, ram_mfa, ram_rw, ram_size, ram_addr, ram_wdata};
    check_eq("wr_req", ram_snap, {59'd0, 1'b1, 1'b0, 2'b01, 32'h20, 32'hDEADBEEF});
    check_eq("wr_gnt", gnt, 2'b10);
    d_addr  = 32'hFFFF_0000;
    d_wdata = 32'h0;
    d_size  = 2'b10;
    d_rw    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wr_stable", {59'd0, ram_mfa, ram_rw, ram_size, ram_addr, ram_wdata},
               {59'd0, 1'b1, 1'b0, 2'b01, 32'h20, 32'hDEADBEEF});
      check_eq("wr_wait_mfc", d_mfc, 1'b0);
    end
    tick();
    check_eq("wr_done", {d_mfc, ram_mfa, d_rdata}, {1'b1, 1'b0, 32'h11112222});
    d_mfa = 1'b0;
    tick();
    check_eq("wr_idle", {gnt, d_mfc}, 3'b000);

    // Simultaneous pair after D was served last: IF first, then D
    ram_wait  = 0;
    ram_rdata = 32'h55;
    d_rw      = 1'b1;
    d_size    = 2'b10;
    d_addr    = 32'h40;
    if_addr   = 32'h0C;
    if_mfa    = 1'b1;
    d_mfa     = 1'b1;
    tick();
    check_eq("tie2_gnt_if", {gnt, ram_addr}, {2'b01, 32'h0C});
    tick();
    check_eq("tie2_if_done", {if_mfc, d_mfc, if_rdata}, {1'b1, 1'b0, 32'h55});
    if_mfa    = 1'b0;
    ram_rdata = 32'h66;
    tick();
    tick();
    check_eq("tie2_gnt_d", {gnt, ram_addr}, {2'b10, 32'h40});
    tick();
    check_eq("tie2_d_done", {d_mfc, if_mfc, d_rdata}, {1'b1, 1'b0, 32'h66});
    d_mfa = 1'b0;
    tick();

    // D read withdrawn during BUSY with IF pending
    ram_wait  = 3;
    ram_rdata = 32'h77;
    d_addr    = 32'h50;
    d_mfa     = 1'b1;
    tick();
    check_eq("wd_gnt_d", gnt, 2'b10);
    d_mfa   = 1'b0;
    if_mfa  = 1'b1;
    if_addr = 32'h08;
    cyc     = 0;
    while (gnt != 2'b01 && cyc < 12) begin
      tick();
      cyc++;
      check_eq("wd_no_d_mfc", d_mfc, 1'b0);
    end
    check_eq("wd_cycles_to_if", cyc, 6);
    check_eq("wd_d_rdata_kept", d_rdata, 32'h66);
    ram_wait  = 0;
    ram_rdata = 32'h88;
    tick();
    check_eq("wd_if_done", {if_mfc, d_mfc, if_rdata}, {1'b1, 1'b0, 32'h88});
    if_mfa = 1'b0;
    tick();

    // RAM that never completes
    ram_wait = 100000;
    d_rw     = 1'b0;
    d_size   = 2'b10;
    d_addr   = 32'h10;
    d_wdata  = 32'h12345678;
    d_mfa    = 1'b1;
    tick();
    check_eq("stall_gnt", {gnt, ram_mfa}, 3'b101);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check_eq("to_not_yet", {d_mfc, mem_err, ram_mfa}, 3'b001);
    tick();
    check_eq("to_fire", {d_mfc, mem_err, ram_mfa, if_mfc}, 4'b1100);
    check_eq("to_rdata", d_rdata, 32'h0);
    d_mfa = 1'b0;
    tick();
    check_eq("to_idle", {gnt, mem_err, d_mfc}, 4'b0000);
    d_mfa = 1'b1;
    tick();
    tick();
`else
    for (int i = 0; i < 20; i++) tick();
    check_eq("stall_busy", {ram_mfa, mem_err, d_mfc, gnt}, 5'b10010);
`endif

    // Asynchronous reset in the middle of the D write to 0x10
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ctrl", {ram_mfa, gnt, if_mfc, d_mfc, mem_err}, '0);
    check_eq("arst_data", {ram_addr, ram_wdata, d_rdata}, '0);
    d_mfa    = 1'b0;
    ram_wait = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("arst_no_mfc", {d_mfc, gnt}, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported RAM between two requesters: the CU's instruction-fetch path (requester 0, IF) and its load/store path (requester 1, D).
- Uses the MFA/MFC request/complete handshake on both sides.
- Sits between the CU/datapath and the RAM; the RAM sees exactly one transaction at a time.
- Provides round-robin fairness on simultaneous requests and registers the request/response paths.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum cycles to wait for RAM_MFC (used only with the optional feature).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IF_MFA  in  1  fetch request; held high until IF_MFC is seen.
- IF_ADDR  in  AW  fetch address; reads are always word size.
- IF_MFC  out  1  fetch complete.
- IF_RDATA  out  DW  fetched word; valid while IF_MFC=1.
- D_MFA  in  1  data request; held high until D_MFC is seen.
- D_RW  in  1  1=read, 0=write.
- D_SIZE  in  2  00=byte, 01=half, 10=word.
- D_ADDR  in  AW  data address.
- D_WDATA  in  DW  store data.
- D_MFC  out  1  data complete.
- D_RDATA  out  DW  load data; valid while D_MFC=1.
- RAM_MFA  out  1  RAM request.
- RAM_RW  out  1  RAM read/write.
- RAM_SIZE  out  2  RAM access size.
- RAM_ADDR  out  AW  RAM address.
- RAM_WDATA  out  DW  RAM write data.
- RAM_RDATA  in  DW  RAM read data.
- RAM_MFC  in  1  RAM complete.
- GNT  out  2  current owner, one-hot: bit0=IF, bit1=D; 00 when idle.
- MEM_ERR  out  1  bus-timeout error; valid with the owner's MFC (optional feature).

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs 0 and state IDLE.
  - LAST=IF, so D wins the first tie.
  - Reset mid-transaction abandons the transaction; no MFC is issued afterwards.
- State IDLE:
  - Only D_MFA: grant D.
  - Only IF_MFA: grant IF.
  - Both: grant the requester not equal to LAST.
  - On a grant, latch the winner's address, rw, size and wdata into RAM_* registers; IF forces RW=1 and SIZE=10.
  - Set GNT and LAST; next cycle RAM_MFA=1 and state BUSY.
- State BUSY:
  - Hold RAM_MFA and all RAM_* outputs stable.
  - On the cycle RAM_MFC=1 is sampled: capture RAM_RDATA into the owner's RDATA register (reads only; writes leave it unchanged), drop RAM_MFA, assert the owner's MFC, go to DONE.
- State DONE:
  - Hold the owner's MFC and RDATA.
  - Exit to IDLE when the owner's MFA=0 and RAM_MFC=0 are sampled together.
  - In IDLE, MFC=0 and GNT=00.
  - A new request can be granted on the first IDLE cycle.
- Latency:
  - Request sampled at edge N gives RAM_MFA=1 after edge N.
  - RAM_MFC sampled at edge M gives owner MFC=1 after edge M.
  - Minimum 2 cycles from request to complete with a zero-wait RAM.
- Request withdrawn during BUSY (owner MFA falls):
  - The RAM transaction still completes; writes are not cancelled.
  - The result is discarded and no MFC is asserted; return to IDLE once RAM_MFC=0.
- Requester MFA rises during another's transaction: it stays pending and is served next, with no loss.
- A requester's inputs are ignored except when sampled at grant.
- The non-owner MFC is always 0; IF_MFC and D_MFC are never both 1.
- RAM_ADDR is passed unmodified; no alignment check.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter resets to 0 on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without RAM_MFC, drop RAM_MFA and go to DONE with owner MFC=1, MEM_ERR=1, RDATA=0.
  - MEM_ERR clears on return to IDLE.
  - The DONE exit additionally waits for RAM_MFC=0.
- Undefined: no counter; BUSY waits indefinitely; MEM_ERR is tied to 0.

Test Plan:
- Reset=0 mid-BUSY of a D write to 0x10 -> all outputs 0 immediately (asynchronous); after Reset=1, no D_MFC pulse and GNT=00.
- IF_MFA=1, IF_ADDR=0x04, RAM returns 0xA2044012 with RAM_MFC one cycle after RAM_MFA -> RAM_RW=1, RAM_SIZE=10, IF_MFC=1 with IF_RDATA=0xA2044012 two edges after the request; IDLE one cycle after IF_MFA drops.
- IF_MFA and D_MFA rise in the same cycle after reset -> D served first (GNT=10), then IF (GNT=01); a second simultaneous pair is served IF first, then D.
- D write: D_ADDR=0x20, D_WDATA=0xDEADBEEF, D_SIZE=01, RAM_MFC delayed 5 cycles -> RAM_* stable for all 5 cycles; D_MFC=1; D_RDATA unchanged.
- D_MFA withdrawn during BUSY -> RAM transaction finishes; D_MFC never rises; a pending IF_MFA is granted next.
- With ARB_TIMEOUT_EN, TIMEOUT=16, RAM_MFC never asserted -> after 16 BUSY cycles: RAM_MFA=0, D_MFC=1, MEM_ERR=1, D_RDATA=0. Without the macro, the arbiter stays in BUSY with MEM_ERR=0.
